switch_alloc_rr_np: RTL and testbench



---
 rtl/switch_alloc_rr_np.sv | 138 +++++++++++++
 tb/tb_switch_alloc_rr_np.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_alloc_rr_np.sv
// switch_alloc_rr_np: N-port switch allocator, per-output round-robin, optional wormhole lock (`SA_PKT_LOCK_EN`).
// Latency: request-to-grant 0 cycles (in_grant combinational); grant-to-crossbar select (out_vld/out_sel) 1 cycle.
// Backpressure: an output without out_ready, or en low, grants nothing; ungranted requesters hold their flit.
module switch_alloc_rr_np #(
    parameter  int NPORT = 5,
    localparam int IDX_W = $clog2(NPORT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NPORT-1:0]       in_req,
    input  logic [NPORT*IDX_W-1:0] in_dst,
    input  logic [NPORT-1:0]       in_tail,
    input  logic [NPORT-1:0]       out_ready,
    output logic [NPORT-1:0]       in_grant,
    output logic [NPORT-1:0]       out_vld,
    output logic [NPORT*IDX_W-1:0] out_sel
);

    // Round-robin pointer per output: the input searched first in the next arbitration.
    logic [IDX_W-1:0] ptr [NPORT];

    // cand[o][i]: input i is an eligible requester of output o this cycle.
    logic [NPORT-1:0] cand [NPORT];

    // Per-output arbitration result.
    logic [NPORT-1:0] out_gnt;
    logic [IDX_W-1:0] win    [NPORT];
    logic [NPORT-1:0] win_oh [NPORT];

    // Distance scratch for the circular search.
    int best_dist;
    int cur_dist;

`ifdef SA_PKT_LOCK_EN
    // Wormhole lock: output o is reserved for lock_in[o] until that input's tail flit is granted.
    logic [NPORT-1:0] lock_vld;
    logic [IDX_W-1:0] lock_in [NPORT];
    logic [NPORT-1:0] win_tail;
`else
    // Without packet locking every flit arbitrates on its own, so the tail marker carries no meaning here.
    logic unused_tail;
    assign unused_tail = ^in_tail;
`endif

    // Build the request matrix; destinations >= NPORT never match any output and are thus never granted.
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                cand[o][i] = in_req[i] && (in_dst[i*IDX_W +: IDX_W] == IDX_W'(o));
`ifdef SA_PKT_LOCK_EN
                // A locked output only listens to its lock holder.
                if (lock_vld[o] && (lock_in[o] != IDX_W'(i))) begin
                    cand[o][i] = 1'b0;
                end
`endif
            end
        end
    end

    // Per-output circular search starting at ptr[o]; the candidate with the smallest
    // forward distance from the pointer wins.
    always_comb begin
        best_dist = NPORT;
        cur_dist  = 0;
        out_gnt   = '0;
        in_grant  = '0;
`ifdef SA_PKT_LOCK_EN
        win_tail  = '0;
`endif
        for (int o = 0; o < NPORT; o++) begin
            win[o]    = '0;
            win_oh[o] = '0;
            best_dist = NPORT;
            for (int i = 0; i < NPORT; i++) begin
                cur_dist = (i >= int'(ptr[o])) ? (i - int'(ptr[o]))
                                               : (i + NPORT - int'(ptr[o]));
                if (cand[o][i] && (cur_dist < best_dist)) begin
                    best_dist    = cur_dist;
                    win[o]       = IDX_W'(i);
                    win_oh[o]    = '0;
                    win_oh[o][i] = 1'b1;
`ifdef SA_PKT_LOCK_EN
                    win_tail[o]  = in_tail[i];
`endif
                end
            end
            // Each input names a single destination, so OR-ing the per-output
            // one-hots never gives an input two grants.
            if (!rst && en && out_ready[o] && (best_dist < NPORT)) begin
                out_gnt[o] = 1'b1;
                in_grant   = in_grant | win_oh[o];
            end
        end
    end

    // Pointer advance and crossbar select registers; out_sel holds when its output idles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= '0;
            out_sel <= '0;
            for (int o = 0; o < NPORT; o++) begin
                ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                out_vld[o] <= out_gnt[o];
                if (out_gnt[o]) begin
                    out_sel[o*IDX_W +: IDX_W] <= win[o];
                    // While locked the winner is always lock_in[o], and the head grant
                    // already set ptr to lock_in+1, so the pointer effectively holds
                    // through the packet and lands on lock_in+1 at the tail.
                    ptr[o] <= (int'(win[o]) == NPORT - 1) ? '0 : (win[o] + IDX_W'(1));
                end
            end
        end
    end

`ifdef SA_PKT_LOCK_EN
    // Lock state: a non-tail grant reserves the output for its winner, a tail grant releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld <= '0;
            for (int o = 0; o < NPORT; o++) begin
                lock_in[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (out_gnt[o]) begin
                    lock_vld[o] <= !win_tail[o];
                    lock_in[o]  <= win[o];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_switch_alloc_rr_np.sv
// tb_switch_alloc_rr_np: directed scenarios plus constrained-random traffic against a reference model.
// Latency: model predicts in_grant in the same cycle and out_vld/out_sel one cycle later.
// Backpressure: out_ready and en are driven directly; requesters hold dst/tail while waiting.
module tb_switch_alloc_rr_np;

    localparam int N = 5;
    localparam int W = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N-1:0]   in_req;
    logic [N*W-1:0] in_dst;
    logic [N-1:0]   in_tail;
    logic [N-1:0]   out_ready;
    logic [N-1:0]   in_grant;
    logic [N-1:0]   out_vld;
    logic [N*W-1:0] out_sel;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SA_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    switch_alloc_rr_np #(.NPORT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_req    (in_req),
        .in_dst    (in_dst),
        .in_tail   (in_tail),
        .out_ready (out_ready),
        .in_grant  (in_grant),
        .out_vld   (out_vld),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    // Reference model state, kept as plain integers per output.
    int m_ptr      [N];
    bit m_lock_vld [N];
    int m_lock_in  [N];
    int m_sel      [N];
    bit m_vld      [N];
    bit m_g        [N];
    int m_w        [N];
    bit m_t        [N];

    logic [N-1:0]   exp_grant, obs_grant, exp_vld, obs_vld;
    logic [N*W-1:0] exp_sel, obs_sel;

    function automatic int dst_of(int i);
        return int'(in_dst[i*W +: W]);
    endfunction

    task automatic set_dst(int i, int d);
        in_dst[i*W +: W] = W'(d);
    endtask

    // Winner per output from the allocation rules, using the current inputs.
    task automatic model_comb();
        int w;
        exp_grant = '0;
        for (int o = 0; o < N; o++) begin
            m_g[o] = 1'b0;
            m_w[o] = 0;
            m_t[o] = 1'b0;
            if (!rst && en && out_ready[o]) begin
                if (m_lock_vld[o]) begin
                    w = m_lock_in[o];
                    if (in_req[w] && dst_of(w) == o) begin
                        m_g[o] = 1'b1;
                        m_w[o] = w;
                    end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        w = (m_ptr[o] + k) % N;
                        if (!m_g[o] && in_req[w] && dst_of(w) == o) begin
                            m_g[o] = 1'b1;
                            m_w[o] = w;
                        end
                    end
                end
            end
            if (m_g[o]) begin
                exp_grant[m_w[o]] = 1'b1;
                m_t[o] = in_tail[m_w[o]];
            end
        end
    endtask

    // State update at the clock edge.
    task automatic model_seq();
        for (int o = 0; o < N; o++) begin
            if (rst) begin
                m_ptr[o] = 0; m_lock_vld[o] = 1'b0; m_lock_in[o] = 0;
                m_vld[o] = 1'b0; m_sel[o] = 0;
            end else begin
                m_vld[o] = m_g[o];
                if (m_g[o]) begin
                    m_sel[o]      = m_w[o];
                    m_ptr[o]      = (m_w[o] + 1) % N;
                    m_lock_vld[o] = LOCK && !m_t[o];
                    m_lock_in[o]  = m_w[o];
                end
            end
            exp_vld[o]         = m_vld[o];
            exp_sel[o*W +: W]  = W'(m_sel[o]);
        end
    endtask

    // One clock: sample grant mid-cycle, registered outputs just after the edge.
    task automatic cycle();
        @(negedge clk);
        model_comb();
        obs_grant = in_grant;
        @(posedge clk);
        model_seq();
        #1;
        obs_vld = out_vld;
        obs_sel = out_sel;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; out_ready = '1; in_req = '1; in_tail = '1;
        for (int i = 0; i < N; i++) set_dst(i, $urandom_range(N-1));
        for (int c = 0; c < 2; c++) begin
            cycle();
            n_checks++;
            if (obs_grant !== '0) begin
                n_errors++;
                $display("FAIL reset_grant cyc%0d got %b want 0", c, obs_grant);
            end
        end
        n_checks++;
        if (obs_vld !== '0) begin
            n_errors++; $display("FAIL reset_vld got %b want 0", obs_vld);
        end
        n_checks++;
        if (obs_sel !== '0) begin
            n_errors++; $display("FAIL reset_sel got %h want 0", obs_sel);
        end
        rst = 1'b0; in_req = '0;
        cycle();
        n_checks++;
        if (obs_vld !== '0 || exp_vld !== '0) begin
            n_errors++; $display("FAIL reset_idle_vld got %b want 0", obs_vld);
        end
    endtask

    task automatic test_fairness();
        int seq [6] = '{0, 2, 4, 0, 2, 4};
        logic [N-1:0] want;
        in_req = 5'b10101; in_tail = '1; out_ready = '1; en = 1'b1;
        for (int i = 0; i < N; i++) set_dst(i, 1);
        for (int k = 0; k < 6; k++) begin
            cycle();
            want = '0;
            want[seq[k]] = 1'b1;
            n_checks++;
            if (obs_grant !== want) begin
                n_errors++; $display("FAIL fair_grant step%0d got %b want %b", k, obs_grant, want);
            end
            n_checks++;
            if (obs_grant !== exp_grant) begin
                n_errors++; $display("FAIL fair_model step%0d got %b want %b", k, obs_grant, exp_grant);
            end
            n_checks++;
            if (obs_vld[1] !== 1'b1 || obs_sel[1*W +: W] !== W'(seq[k])) begin
                n_errors++;
                $display("FAIL fair_sel step%0d got vld=%b sel=%0d want vld=1 sel=%0d",
                         k, obs_vld[1], obs_sel[1*W +: W], seq[k]);
            end
        end
        in_req = '0;
    endtask

    task automatic test_lock();
        int tbl [$];
        int left;
        logic [N-1:0] want;
`ifdef SA_PKT_LOCK_EN
        tbl = '{3, 3, 3, 3, 1};
`else
        tbl = '{3, 1, 3, 1, 3, 1, 3};
`endif
        // Single flit from input 2 moves ptr[0] to 3 so input 3 wins the head.
        in_req = 5'b00100; in_tail = '1; set_dst(2, 0);
        cycle();
        n_checks++;
        if (obs_grant !== 5'b00100) begin
            n_errors++; $display("FAIL lock_prime got %b want 00100", obs_grant);
        end
        in_req = '0; in_req[1] = 1'b1; set_dst(1, 0); set_dst(3, 0);
        left = 4;
        foreach (tbl[k]) begin
            in_req[3]  = (left > 0);
            in_tail[3] = (left == 1);
            cycle();
            want = '0;
            want[tbl[k]] = 1'b1;
            n_checks++;
            if (obs_grant !== want) begin
                n_errors++; $display("FAIL lock_grant step%0d got %b want %b", k, obs_grant, want);
            end
            n_checks++;
            if (obs_grant !== exp_grant || obs_sel !== exp_sel) begin
                n_errors++;
                $display("FAIL lock_model step%0d got g=%b sel=%h want g=%b sel=%h",
                         k, obs_grant, obs_sel, exp_grant, exp_sel);
            end
            if (obs_grant[3]) left--;
        end
        n_checks++;
        if (left != 0) begin
            n_errors++; $display("FAIL lock_flits got %0d left want 0", left);
        end
        in_req = '0; in_tail = '1;
        cycle();
    endtask

    task automatic test_backpressure();
        in_req = 5'b00001; in_tail = '1; set_dst(0, 2); out_ready = 5'b11011; en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_checks++;
            if (obs_grant !== '0 || obs_vld[2] !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_stall cyc%0d got g=%b vld2=%b want g=0 vld2=0", c, obs_grant, obs_vld[2]);
            end
        end
        out_ready = '1;
        cycle();
        n_checks++;
        if (obs_grant !== 5'b00001) begin
            n_errors++; $display("FAIL bp_release got %b want 00001", obs_grant);
        end
        n_checks++;
        if (obs_vld[2] !== 1'b1 || obs_sel[2*W +: W] !== W'(0)) begin
            n_errors++;
            $display("FAIL bp_sel got vld=%b sel=%0d want vld=1 sel=0", obs_vld[2], obs_sel[2*W +: W]);
        end
        in_req = '0;
        cycle();
    endtask

    task automatic test_dst_en();
        logic [N-1:0] want_resume;
`ifdef SA_PKT_LOCK_EN
        want_resume = 5'b10000;
`else
        want_resume = 5'b00001;
`endif
        out_ready = '1; en = 1'b1; in_tail = '1;
        in_req = 5'b10010; set_dst(1, 7); set_dst(4, 3); in_tail[4] = 1'b0;
        cycle();
        n_checks++;
        if (obs_grant !== 5'b10000) begin
            n_errors++; $display("FAIL dst_head got %b want 10000", obs_grant);
        end
        en = 1'b0; in_req[0] = 1'b1; set_dst(0, 3);
        for (int c = 0; c < 2; c++) begin
            cycle();
            n_checks++;
            if (obs_grant !== '0 || obs_vld !== '0) begin
                n_errors++;
                $display("FAIL en_off cyc%0d got g=%b vld=%b want 0", c, obs_grant, obs_vld);
            end
        end
        en = 1'b1;
        cycle();
        n_checks++;
        if (obs_grant !== want_resume) begin
            n_errors++; $display("FAIL en_resume got %b want %b", obs_grant, want_resume);
        end
        in_tail[4] = 1'b1;
        cycle();
        n_checks++;
        if (obs_grant !== 5'b10000) begin
            n_errors++; $display("FAIL en_tail got %b want 10000", obs_grant);
        end
        in_req[4] = 1'b0;
        cycle();
        n_checks++;
        if (obs_grant !== exp_grant || obs_grant[1] !== 1'b0) begin
            n_errors++; $display("FAIL dst_range got %b want %b", obs_grant, exp_grant);
        end
        in_req = '0;
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(99) == 0);
            en  = ($urandom_range(9) != 0);
            out_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
                // A waiting requester keeps its flit; otherwise draw a fresh one.
                if (!(in_req[i] && !obs_grant[i])) begin
                    in_req[i]  = ($urandom_range(3) != 0);
                    in_tail[i] = ($urandom_range(2) == 0);
                    set_dst(i, ($urandom_range(9) == 0) ? 7 : $urandom_range(N-1));
                end
            end
            cycle();
            n_checks++;
            if (obs_grant !== exp_grant) begin
                n_errors++; $display("FAIL rnd_grant cyc%0d got %b want %b", c, obs_grant, exp_grant);
            end
            n_checks++;
            if (obs_vld !== exp_vld) begin
                n_errors++; $display("FAIL rnd_vld cyc%0d got %b want %b", c, obs_vld, exp_vld);
            end
            n_checks++;
            if (obs_sel !== exp_sel) begin
                n_errors++; $display("FAIL rnd_sel cyc%0d got %h want %h", c, obs_sel, exp_sel);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; in_req = '0; in_dst = '0; in_tail = '0; out_ready = '0;
        obs_grant = '0; exp_vld = '0; exp_sel = '0; exp_grant = '0;
        for (int o = 0; o < N; o++) begin
            m_ptr[o] = 0; m_lock_vld[o] = 1'b0; m_lock_in[o] = 0;
            m_vld[o] = 1'b0; m_sel[o] = 0; m_g[o] = 1'b0; m_w[o] = 0; m_t[o] = 1'b0;
        end
        test_reset();
        test_fairness();
        test_lock();
        test_backpressure();
        test_dst_en();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
